// File: rtl/plru_state_array_pkg.sv
// Shared types for the 4-way tree pseudo-LRU state array and victim selector.
package plru_state_array_pkg;

    typedef logic [2:0] lc3b_plru_state;
    typedef logic [1:0] lc3b_way;
    typedef logic [3:0] lc3b_way_valid;

    localparam logic [0:0] FsmIdle  = 1'b0;
    localparam logic [0:0] FsmFlush = 1'b1;

endpackage

// File: rtl/plru_state_array_if.sv
// Lookup, update and flush signals between the cache controller and the PLRU state array.
interface plru_state_array_if #(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) ();
    import plru_state_array_pkg::*;

    logic [IDX_W-1:0] rd_index;
    lc3b_plru_state   lru_state;
    lc3b_way          victim_way;
    logic             set_full;
    logic             upd_en;
    logic [IDX_W-1:0] upd_index;
    lc3b_plru_state   upd_state;
    logic             fill_en;
    lc3b_way          fill_way;
    logic             flush_req;
    logic             busy;

    modport master (
        output rd_index, upd_en, upd_index, upd_state, fill_en, fill_way, flush_req,
        input  lru_state, victim_way, set_full, busy
    );

    modport slave (
        input  rd_index, upd_en, upd_index, upd_state, fill_en, fill_way, flush_req,
        output lru_state, victim_way, set_full, busy
    );

endinterface

// File: rtl/plru_victim_sel.sv
// Combinational victim choice for a 4-way tree PLRU: invalid ways first, then the tree.
module plru_victim_sel
    import plru_state_array_pkg::*;
(
    input  lc3b_plru_state state_i,
    input  lc3b_way_valid  valid_i,
    output lc3b_way        victim_o,
    output logic           set_full_o
);

    always_comb begin
        victim_o = 2'd0;
        if (!valid_i[0]) begin
            victim_o = 2'd0;
        end else if (!valid_i[1]) begin
            victim_o = 2'd1;
        end else if (!valid_i[2]) begin
            victim_o = 2'd2;
        end else if (!valid_i[3]) begin
            victim_o = 2'd3;
        end else if (!state_i[0]) begin
            // Lower pair used last: evict the colder way of the upper pair.
            victim_o = {1'b1, ~state_i[2]};
        end else begin
            victim_o = {1'b0, ~state_i[1]};
        end
    end

    assign set_full_o = &valid_i;

endmodule

// File: rtl/plru_state_array.sv
// Per-set PLRU state and valid bits with zero-latency reads and a set-by-set flush sequencer.
module plru_state_array
    import plru_state_array_pkg::*;
#(
    parameter int unsigned NUM_SETS = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_SETS)
) (
    input logic               clk,
    input logic               reset_n,
    plru_state_array_if.slave bus
);

    logic [0:0]       fsm_q, fsm_d;
    logic [IDX_W-1:0] flush_ptr_q, flush_ptr_d;
    logic             busy;

    lc3b_plru_state state_q [NUM_SETS];
    lc3b_plru_state state_d [NUM_SETS];
    lc3b_way_valid  valid_q [NUM_SETS];
    lc3b_way_valid  valid_d [NUM_SETS];

    lc3b_plru_state rd_state;
    lc3b_way_valid  rd_valid;
    lc3b_way        sel_victim;
    logic           sel_full;

    assign busy = (fsm_q == FsmFlush);

    always_comb begin
        fsm_d       = fsm_q;
        flush_ptr_d = flush_ptr_q;
        case (fsm_q)
            FsmIdle: begin
                if (bus.flush_req) begin
                    fsm_d       = FsmFlush;
                    flush_ptr_d = '0;
                end
            end
            FsmFlush: begin
                flush_ptr_d = flush_ptr_q + 1'b1;
                if (flush_ptr_q == IDX_W'(NUM_SETS - 1)) begin
                    fsm_d = FsmIdle;
                end
            end
            default: fsm_d = FsmIdle;
        endcase
    end

    // Controller writes are dropped while flushing; it is expected to stall.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        if (busy) begin
            state_d[flush_ptr_q] = '0;
            valid_d[flush_ptr_q] = '0;
        end else begin
            if (bus.upd_en) begin
                state_d[bus.upd_index] = bus.upd_state;
            end
            if (bus.fill_en) begin
                valid_d[bus.upd_index][bus.fill_way] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= FsmIdle;
            flush_ptr_q <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                state_q[i] <= '0;
                valid_q[i] <= '0;
            end
        end else begin
            fsm_q       <= fsm_d;
            flush_ptr_q <= flush_ptr_d;
            state_q     <= state_d;
            valid_q     <= valid_d;
        end
    end

    // No bypass from the write port, so next-state logic never loops through here.
    assign rd_state = state_q[bus.rd_index];
    assign rd_valid = valid_q[bus.rd_index];

    plru_victim_sel u_victim_sel (
        .state_i    (rd_state),
        .valid_i    (rd_valid),
        .victim_o   (sel_victim),
        .set_full_o (sel_full)
    );

    assign bus.lru_state  = busy ? 3'b000 : rd_state;
    assign bus.victim_way = busy ? 2'b00  : sel_victim;
    assign bus.set_full   = busy ? 1'b0   : sel_full;
    assign bus.busy       = busy;

endmodule
